// File: rtl/scaled_image_renderer_pkg.sv
// Shared types and constants for the scaled image renderer.
// The fade helper is only called when SCALED_IMAGE_FADE_EN is defined.
package scaled_image_pkg;

  localparam int DRAW_W   = 10;
  localparam int FADE_MAX = 16;
  localparam int COLOR_W  = 4;

  typedef struct packed {
    logic [COLOR_W-1:0] red;
    logic [COLOR_W-1:0] green;
    logic [COLOR_W-1:0] blue;
  } rgb4_t;

  // (c * lvl) >> 4, truncated to one colour channel
  function automatic logic [COLOR_W-1:0] fade_scale(input logic [COLOR_W-1:0] c,
                                                    input logic [4:0]         lvl);
    logic [COLOR_W+4:0] prod;
    prod = {5'b0, c} * {{COLOR_W{1'b0}}, lvl};
    return prod[COLOR_W+3:4];
  endfunction

endpackage

// File: rtl/scaled_image_renderer_dda.sv
// One-axis DDA scaler: o_pos = floor(n*SRC_N/DST_N) for the current step count n,
// produced combinationally from the state left by the previous step.
module image_scaler_dda #(
  parameter int SRC_N = 360,
  parameter int DST_N = 640,
  parameter int POS_W = $clog2(SRC_N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_restart,
  input  logic             i_step,
  output logic [POS_W-1:0] o_pos
);

  localparam int ACC_W = $clog2(DST_N);
  localparam int SUM_W = ACC_W + 1;

  logic [POS_W-1:0] r_pos;
  logic [ACC_W-1:0] r_acc;
  logic [SUM_W-1:0] w_sum;
  logic [ACC_W-1:0] w_acc;
  logic [POS_W-1:0] w_pos;

  // Restart wins over step; SRC_N <= DST_N keeps it to one increment per step.
  always_comb begin
    w_acc = r_acc;
    w_pos = r_pos;
    w_sum = '0;
    if (i_restart) begin
      w_acc = '0;
      w_pos = '0;
    end else if (i_step) begin
      w_sum = {1'b0, r_acc} + SUM_W'(SRC_N);
      if (w_sum >= SUM_W'(DST_N)) begin
        w_acc = ACC_W'(w_sum - SUM_W'(DST_N));
        if (r_pos != POS_W'(SRC_N - 1)) begin
          w_pos = r_pos + POS_W'(1);
        end
      end else begin
        w_acc = w_sum[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos <= '0;
      r_acc <= '0;
    end else begin
      r_pos <= w_pos;
      r_acc <= w_acc;
    end
  end

  assign o_pos = w_pos;

endmodule

// File: rtl/scaled_image_renderer.sv
// Full-screen indexed-colour image upscaler between VGA timing and the colour mux.
// Optional fade-in per frame is enabled by defining SCALED_IMAGE_FADE_EN.
module scaled_image_renderer
  import scaled_image_pkg::*;
#(
  parameter int SRC_W     = 360,
  parameter int SRC_H     = 75,
  parameter int DST_W     = 640,
  parameter int DST_H     = 480,
  parameter int IMG_COUNT = 2,
  parameter int PIX_BITS  = 3,
  parameter int ADDR_W    = $clog2(IMG_COUNT * SRC_W * SRC_H),
  parameter int SEL_W     = (IMG_COUNT > 1) ? $clog2(IMG_COUNT) : 1
) (
  input  logic                vga_clk,
  input  logic                reset_n,
  input  logic [DRAW_W-1:0]   DrawX,
  input  logic [DRAW_W-1:0]   DrawY,
  input  logic                blank,
  input  logic [SEL_W-1:0]    img_sel,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [PIX_BITS-1:0] rom_q,
  output logic [PIX_BITS-1:0] pal_index,
  input  logic [COLOR_W-1:0]  pal_red,
  input  logic [COLOR_W-1:0]  pal_green,
  input  logic [COLOR_W-1:0]  pal_blue,
  output logic [COLOR_W-1:0]  red,
  output logic [COLOR_W-1:0]  green,
  output logic [COLOR_W-1:0]  blue
);

  localparam int IMG_SIZE = SRC_W * SRC_H;
  localparam int XPOS_W   = $clog2(SRC_W);
  localparam int YPOS_W   = $clog2(SRC_H);

  logic              w_line_start;
  logic              w_frame_start;
  logic              w_row_step;
  logic [XPOS_W-1:0] w_src_x;
  logic [YPOS_W-1:0] w_src_y;
  logic [YPOS_W-1:0] r_src_y;
  logic [ADDR_W-1:0] r_row_base;
  logic [ADDR_W-1:0] w_row_base;
  logic [SEL_W-1:0]  r_img_cur;
  logic [SEL_W-1:0]  w_img_cur_nxt;
  logic [ADDR_W-1:0] r_img_base;
  logic [ADDR_W-1:0] w_img_base_nxt;
  logic [ADDR_W-1:0] w_img_base;
  logic              r_blank_d1;
  rgb4_t             w_rgb;
  rgb4_t             r_rgb;

  assign w_line_start  = (DrawX == '0);
  assign w_frame_start = w_line_start && (DrawY == '0);
  assign w_row_step    = w_line_start && (DrawY != '0);

  image_scaler_dda #(.SRC_N(SRC_W), .DST_N(DST_W), .POS_W(XPOS_W)) u_dda_x (
    .clk       (vga_clk),
    .rst_n     (reset_n),
    .i_restart (w_line_start),
    .i_step    (1'b1),
    .o_pos     (w_src_x)
  );

  image_scaler_dda #(.SRC_N(SRC_H), .DST_N(DST_H), .POS_W(YPOS_W)) u_dda_y (
    .clk       (vga_clk),
    .rst_n     (reset_n),
    .i_restart (w_frame_start),
    .i_step    (w_row_step),
    .o_pos     (w_src_y)
  );

  // Row base follows src_y by adding one source row per vertical increment.
  always_comb begin
    w_row_base = r_row_base;
    if (w_frame_start) begin
      w_row_base = '0;
    end else if (w_src_y != r_src_y) begin
      w_row_base = r_row_base + ADDR_W'(SRC_W);
    end
  end

  // Out-of-range selections keep the current image.
  always_comb begin
    w_img_cur_nxt = r_img_cur;
    if (int'(img_sel) < IMG_COUNT) begin
      w_img_cur_nxt = img_sel;
    end
    w_img_base_nxt = ADDR_W'(int'(w_img_cur_nxt) * IMG_SIZE);
    w_img_base     = w_frame_start ? w_img_base_nxt : r_img_base;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_src_y    <= '0;
      r_row_base <= '0;
      r_img_cur  <= '0;
      r_img_base <= '0;
    end else begin
      r_src_y    <= w_src_y;
      r_row_base <= w_row_base;
      if (w_frame_start) begin
        r_img_cur  <= w_img_cur_nxt;
        r_img_base <= w_img_base_nxt;
      end
    end
  end

  // Gated so the address reads zero while reset is held, even mid-line.
  assign rom_addr  = reset_n ? (w_img_base + w_row_base + ADDR_W'(w_src_x)) : '0;
  assign pal_index = rom_q;

`ifdef SCALED_IMAGE_FADE_EN
  logic [4:0] r_fade_lvl;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fade_lvl <= '0;
    end else if (w_frame_start) begin
      if (w_img_cur_nxt != r_img_cur) begin
        r_fade_lvl <= '0;
      end else if (r_fade_lvl < 5'(FADE_MAX)) begin
        r_fade_lvl <= r_fade_lvl + 5'd1;
      end
    end
  end

  always_comb begin
    w_rgb       = '0;
    w_rgb.red   = fade_scale(pal_red,   r_fade_lvl);
    w_rgb.green = fade_scale(pal_green, r_fade_lvl);
    w_rgb.blue  = fade_scale(pal_blue,  r_fade_lvl);
  end
`else
  always_comb begin
    w_rgb       = '0;
    w_rgb.red   = pal_red;
    w_rgb.green = pal_green;
    w_rgb.blue  = pal_blue;
  end
`endif

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blank_d1 <= 1'b0;
      r_rgb      <= '0;
    end else begin
      r_blank_d1 <= blank;
      r_rgb      <= r_blank_d1 ? w_rgb : '0;
    end
  end

  assign red   = r_rgb.red;
  assign green = r_rgb.green;
  assign blue  = r_rgb.blue;

endmodule
